// File: rtl/data_memory_sp_if.sv
// data_memory_sp_if: bus bundle between the datapath/CU and data_memory_sp
//   master drives data_in, address, w, push, pop, err_clr
//   slave  drives data_out, top, sp, count, full, empty, err
interface data_memory_sp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] address;
    logic              w;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] top;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              err;

    modport master (
        output data_in, address, w, push, pop, err_clr,
        input  data_out, top, sp, count, full, empty, err
    );

    modport slave (
        input  data_in, address, w, push, pop, err_clr,
        output data_out, top, sp, count, full, empty, err
    );
endinterface

// File: rtl/data_memory_sp.sv
// data_memory_sp: single-port data RAM (async read, sync write) with a built-in downward-growing stack
//   clk, rst_n        : clock, synchronous active-low reset (array contents are not reset)
//   bus.data_in       : write data for w / push;  bus.address : random-access address
//   bus.w/push/pop    : random write, stack push, stack pop (stack op beats w)
//   bus.err_clr       : clears sticky err
//   bus.data_out/top  : mem[address], mem[sp+1] (combinational)
//   bus.sp/count/full/empty/err : registered stack status
//   Define DMEM_STACK_GUARD_EN to reject push-when-full / pop-when-empty and raise err;
//   otherwise sp wraps freely, count saturates and err stays 0.
module data_memory_sp #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input logic               clk,
    input logic               rst_n,
    data_memory_sp_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] sp_q, sp_n, sp_up, wa;
    logic [ADDR_W:0]   cnt_q, cnt_n;
    logic              err_q, err_n;
    logic              full, empty, replace, push_op, pop_op, push_rej, pop_rej, push_ok, pop_ok, we;

    always_comb begin
        sp_up   = sp_q + 1'b1;
        full    = cnt_q == FULL_CNT;
        empty   = cnt_q == '0;
        // push+pop on a non-empty stack overwrites top in place
        replace = bus.push & bus.pop & ~empty;
        push_op = bus.push & (~bus.pop | empty);
        pop_op  = bus.pop & ~bus.push;
`ifdef DMEM_STACK_GUARD_EN
        push_rej = push_op & full;
        pop_rej  = pop_op & empty;
        err_n    = push_rej | pop_rej | (err_q & ~bus.err_clr);
`else
        push_rej = 1'b0;
        pop_rej  = 1'b0;
        // never set after reset, so err reads as 0
        err_n    = err_q & ~bus.err_clr;
`endif
        push_ok = push_op & ~push_rej;
        pop_ok  = pop_op & ~pop_rej;
        sp_n    = push_ok ? sp_q - 1'b1 : pop_ok ? sp_up : sp_q;
        // the full/empty terms only matter unguarded, where count saturates while sp moves
        cnt_n   = (push_ok & ~full) ? cnt_q + 1'b1 : (pop_ok & ~empty) ? cnt_q - 1'b1 : cnt_q;
        we      = push_ok | replace | (bus.w & ~bus.push & ~bus.pop);
        wa      = push_ok ? sp_q : replace ? sp_up : bus.address;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= SP_INIT;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_n;
            cnt_q <= cnt_n;
            err_q <= err_n;
        end
    end

    always_ff @(posedge clk)
        if (rst_n && we) mem[wa] <= bus.data_in;

    assign bus.data_out = mem[bus.address];
    assign bus.top      = mem[sp_up];
    assign bus.sp       = sp_q;
    assign bus.count    = cnt_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.err      = err_q;
endmodule

// File: doc/data_memory_sp.md
# data_memory_sp

Parametrised successor of the CPU data memory: a single-port RAM with asynchronous read and synchronous write, plus a built-in hardware stack (push/pop with stack pointer and occupancy tracking) for CALL/RET and PUSH/POP instructions. It sits in the datapath in place of the plain data memory. It takes ALU output as write data, mux_data output as address, and the CU write enable and stack controls.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- SP_INIT, 2**ADDR_W-1, stack pointer value after reset; the stack grows downward

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- data_in  in  DATA_W  write data for w and push (ALU output)
- address  in  ADDR_W  random-access address (k8 or regB via mux_data)
- w  in  1  random-access write enable (CU D_W)
- push  in  1  stack push request
- pop  in  1  stack pop request
- err_clr  in  1  clears the sticky err flag
- data_out  out  DATA_W  mem[address], combinational
- top  out  DATA_W  mem[sp+1] (mod depth), combinational; the value a pop returns
- sp  out  ADDR_W  current stack pointer
- count  out  ADDR_W+1  stack occupancy, 0..2**ADDR_W
- full  out  1  count == 2**ADDR_W
- empty  out  1  count == 0
- err  out  1  sticky overflow/underflow flag

## Operation
- Memory array contents are not affected by reset; contents after power-up are undefined.
- Reset (rst_n=0 at the edge): sp<=SP_INIT, count<=0, err<=0. Resulting outputs are empty=1, full=0, and data_out and top follow the array.
- Reset has priority over every other input. A push, pop or w issued in the same cycle as reset is discarded and no array write occurs.
- Reads are asynchronous: data_out=mem[address] and top=mem[(sp+1) mod 2**ADDR_W]. All pointer arithmetic is modulo 2**ADDR_W.
- Priority per cycle, from highest to lowest:
  - rst_n
  - stack operation (push or pop)
  - w
- When a stack operation is active, w is ignored and the array is not written at address.
- Operation by case (when not rejected by the guard):
  - Push only: mem[sp]<=data_in, sp<=sp-1, count<=count+1.
  - Pop only: sp<=sp+1, count<=count-1. The popped value is top during the pop cycle; no array write occurs.
  - Push and pop together, count>0: replace top. mem[sp+1]<=data_in; sp and count are unchanged.
  - Push and pop together, count==0: treated as push only.
  - w only: mem[address]<=data_in.
- err_clr sets err<=0 unless a new error event occurs in the same cycle, in which case err<=1 (set wins).
- The stack region and random-access region share the array. Overlap is not protected: software owns the partitioning.

## Timing
- Read latency is 0 cycles (combinational from address, or from the sp register for top).
- Write latency is 1 cycle: written data is visible on data_out or top immediately after the rising edge.
- sp, count, full, empty and err are registered; each updates on the edge after the request.
- There is no handshake and no stall. Every request completes in the cycle it is presented.
- Back-to-back push/pop on consecutive cycles is supported at full rate.

## Configuration
- DMEM_STACK_GUARD_EN defined:
  - A push when full (and not a simultaneous pop) is rejected: no write, sp and count unchanged, err<=1.
  - A pop when empty (and not a simultaneous push) is rejected: sp and count unchanged, err<=1.
- DMEM_STACK_GUARD_EN undefined:
  - No rejection; sp wraps modulo depth.
  - count saturates at 0 and 2**ADDR_W, but sp still moves.
  - err is tied to 0.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with defaults -> sp=0xFC, count=3, mem[0xFF]=0x11, mem[0xFD]=0x33, top=0x33.
- From that state, pop twice -> top reads 0x33 then 0x22 in the pop cycles; afterwards sp=0xFE, count=1, top=0x11.
- w=1 with address=0x10, data_in=0xA5, then address=0x10 with w=0 -> data_out=0xA5. With push=1 and w=1 together, only the push occurs and mem[0x10] is unchanged.
- push+pop with count=1, top=0x11, data_in=0x77 -> top=0x77, sp and count unchanged. Same with count=0 -> behaves as push, count=1.
- With the guard enabled and ADDR_W=2: push 5 times -> 5th push rejected, count=4, full=1, err=1. err_clr -> err=0. Pop 5 times -> 5th pop rejected, empty=1, err=1.
- Assert rst_n=0 mid-sequence with push=1 -> sp=SP_INIT, count=0, err=0, and the array location at the old sp is not written.
